// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the sequencer state encodings, the grant encoding and the default
// address/data widths used by mem_port_arbiter and its latency counter.
package mem_arb_pkg;

    localparam int ARB_AW = 10;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/arb_lat_cnt.sv
// Memory latency down-counter for the arbiter sequencer.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count cleared, zero flag set)
//   load  - load MEM_LAT-1 (issued in the cycle mem_en is high)
//   dec   - decrement while non-zero
//   zero  - registered flag, high when the count is zero
module arb_lat_cnt #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          zero_r;

    // Next count: load has priority, decrement never wraps below zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = CW'(MEM_LAT - 1);
        end else if (dec && (cnt_r != {CW{1'b0}})) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register and its zero flag, registered together so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            zero_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            zero_r <= (cnt_nxt_s == {CW{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the MEM
// load/store port. Each access runs IDLE -> ISSUE -> WAIT -> DONE; the data
// port normally wins ties, but after STARVE_MAX consecutive data grants with a
// fetch waiting the fetch is forced through.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   if_req/if_addr        - fetch request (level) and word address
//   if_rdata/if_ack       - fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata - data request, store flag, address, store data
//   dm_rdata/dm_ack       - load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata - memory strobe and write interface
//   mem_rdata             - memory read data, valid MEM_LAT cycles after mem_en
//   pipe_stall            - high while any request is pending and not acked
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pipe_stall
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    arb_gnt_e      gnt_r;
    arb_gnt_e      gnt_sel_s;
    logic          we_r;
    logic [SW-1:0] starve_r;
    logic          any_req_s;
    logic          lat_load_s;
    logic          lat_dec_s;
    logic          lat_zero_s;

    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] dm_rdata_r;
    logic          if_ack_r;
    logic          dm_ack_r;
    logic          mem_en_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;

    assign any_req_s = if_req | dm_req;

    arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (reset),
        .load  (lat_load_s),
        .dec   (lat_dec_s),
        .zero  (lat_zero_s)
    );

    // Grant selection: data port wins ties until the fetch has been passed over STARVE_MAX times.
    always_comb begin
        gnt_sel_s = GNT_DM;
        if (if_req && dm_req) begin
            if (starve_r == SW'(STARVE_MAX)) begin
                gnt_sel_s = GNT_IF;
            end else begin
                gnt_sel_s = GNT_DM;
            end
        end else if (if_req) begin
            gnt_sel_s = GNT_IF;
        end else begin
            gnt_sel_s = GNT_DM;
        end
    end

    // Sequencer next-state and latency counter controls.
    always_comb begin
        state_nxt_s = state_r;
        lat_load_s  = 1'b0;
        lat_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                lat_load_s  = 1'b1;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    lat_dec_s   = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch and starvation counter; inputs are only looked at in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_r       <= GNT_IF;
            we_r        <= 1'b0;
            starve_r    <= {SW{1'b0}};
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            gnt_r <= gnt_sel_s;
            if (gnt_sel_s == GNT_DM) begin
                we_r        <= dm_we;
                mem_addr_r  <= dm_addr;
                mem_wdata_r <= dm_wdata;
                if (if_req && (starve_r != SW'(STARVE_MAX))) begin
                    starve_r <= starve_r + SW'(1);
                end
            end else begin
                we_r       <= 1'b0;
                mem_addr_r <= if_addr;
                starve_r   <= {SW{1'b0}};
            end
        end
    end

    // Registered strobes and acks, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
        end else begin
            mem_en_r <= (state_nxt_s == ST_ISSUE);
            mem_we_r <= (state_nxt_s == ST_ISSUE) && (gnt_sel_s == GNT_DM) && dm_we;
            if_ack_r <= (state_nxt_s == ST_DONE) && (gnt_r == GNT_IF);
            dm_ack_r <= (state_nxt_s == ST_DONE) && (gnt_r == GNT_DM);
        end
    end

    // Read data capture on the last WAIT cycle; stores leave dm_rdata untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_r <= {DW{1'b0}};
            dm_rdata_r <= {DW{1'b0}};
        end else if ((state_r == ST_WAIT) && lat_zero_s) begin
            if (gnt_r == GNT_IF) begin
                if_rdata_r <= mem_rdata;
            end else if (!we_r) begin
                dm_rdata_r <= mem_rdata;
            end
        end
    end

    assign if_rdata   = if_rdata_r;
    assign dm_rdata   = dm_rdata_r;
    assign if_ack     = if_ack_r;
    assign dm_ack     = dm_ack_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    // Stall must drop in the ack cycle itself, so this stays combinational.
    assign pipe_stall = reset & ((if_req & ~if_ack_r) | (dm_req & ~dm_ack_r));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = 10'h000;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [9:0]  dm_addr = 10'h000;
    logic [31:0] dm_wdata = 32'h0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        pipe_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(10), .DW(32), .MEM_LAT(2), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: default contents by address, overridden by stores; 2-cycle read latency.
    logic [31:0] wmem [0:1023];
    bit          wvld [0:1023];
    logic        rd_v0 = 1'b0, rd_v1 = 1'b0;
    logic [31:0] rd_d0 = 32'h0, rd_d1 = 32'h0;

    function automatic logic [31:0] mem_default(input logic [9:0] a);
        if (a == 10'h004) return 32'h2001_0005;
        return 32'h1000_0000 | {22'h0, a};
    endfunction

    always @(posedge clk) begin
        rd_v0 <= mem_en && !mem_we;
        rd_d0 <= wvld[mem_addr] ? wmem[mem_addr] : mem_default(mem_addr);
        rd_v1 <= rd_v0;
        rd_d1 <= rd_d0;
        if (mem_en && mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            wvld[mem_addr] <= 1'b1;
        end
    end
    assign mem_rdata = rd_v1 ? rd_d1 : 32'h0;

    // Scoreboard
    typedef struct packed {
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t if_q[$];
    exp_t dm_q[$];
    logic order_q[$];
    bit   order_chk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   men_cnt = 0;
    int   mwe_cnt = 0;
    int   men_last_cyc = -1;
    logic [9:0] men_last_addr = 10'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the expected response whenever an ack is presented.
    always @(negedge clk) begin
        exp_t e;
        logic port;
        if (mem_en) begin
            men_cnt++;
            men_last_cyc = cyc;
            men_last_addr = mem_addr;
            if (mem_we) mwe_cnt++;
        end
        if (if_ack) begin
            if (if_q.size() == 0) begin
                note_fail("if_ack_unexpected");
            end else begin
                e = if_q.pop_front();
                chk("if_rdata", {32'h0, if_rdata}, {32'h0, e.data});
                if (e.ack_cyc >= 0) chk("if_ack_cycle", 64'(cyc), 64'(e.ack_cyc));
            end
            if (order_chk) begin
                if (order_q.size() == 0) note_fail("grant_order_extra_if");
                else begin
                    port = order_q.pop_front();
                    chk("grant_order_if", {63'h0, 1'b0}, {63'h0, port});
                end
            end
        end
        if (dm_ack) begin
            if (dm_q.size() == 0) begin
                note_fail("dm_ack_unexpected");
            end else begin
                e = dm_q.pop_front();
                chk("dm_rdata", {32'h0, dm_rdata}, {32'h0, e.data});
                if (e.ack_cyc >= 0) chk("dm_ack_cycle", 64'(cyc), 64'(e.ack_cyc));
            end
            if (order_chk) begin
                if (order_q.size() == 0) note_fail("grant_order_extra_dm");
                else begin
                    port = order_q.pop_front();
                    chk("grant_order_dm", {63'h0, 1'b1}, {63'h0, port});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold each request until its ack, then drop it in the following cycle.
    task automatic serve(input int budget);
        int n = 0;
        logic ia, da;
        while ((if_req || dm_req) && n < budget) begin
            @(negedge clk);
            ia = if_ack;
            da = dm_ack;
            tick();
            if (ia) if_req = 1'b0;
            if (da) dm_req = 1'b0;
            n++;
        end
        if (if_req || dm_req) begin
            note_fail("serve_timeout");
            if_req = 1'b0;
            dm_req = 1'b0;
        end
    endtask

    // Keep both requests high until n acks have been seen in total.
    task automatic continuous(input int n_acks, input int budget);
        int cnt = 0;
        int n = 0;
        while (cnt < n_acks && n < budget) begin
            @(negedge clk);
            cnt += int'(if_ack) + int'(dm_ack);
            tick();
            n++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        if (cnt < n_acks) note_fail("continuous_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c0;

        // 1: reset with both requests high, then the data port goes first
        if_req = 1'b1; dm_req = 1'b1; if_addr = 10'h020; dm_addr = 10'h030; dm_we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_if_ack", {63'h0, if_ack}, 64'h0);
            chk("rst_dm_ack", {63'h0, dm_ack}, 64'h0);
            chk("rst_mem_en", {63'h0, mem_en}, 64'h0);
            chk("rst_stall", {63'h0, pipe_stall}, 64'h0);
            chk("rst_if_rdata", {32'h0, if_rdata}, 64'h0);
            chk("rst_dm_rdata", {32'h0, dm_rdata}, 64'h0);
        end
        tick();
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        dm_q.push_back('{data: 32'h1000_0030, ack_cyc: -1});
        if_q.push_back('{data: 32'h1000_0020, ack_cyc: -1});
        order_chk = 1'b1;
        reset = 1'b1;
        serve(40);
        order_chk = 1'b0;
        chk("t1_order_drained", 64'(order_q.size()), 64'h0);

        // 2: fetch only, exact latency
        tick();
        t = cyc;
        c0 = men_cnt;
        if_addr = 10'h004;
        if_req = 1'b1;
        if_q.push_back('{data: 32'h2001_0005, ack_cyc: t + 4});
        serve(20);
        chk("t2_mem_en_cycle", 64'(men_last_cyc), 64'(t + 1));
        chk("t2_mem_addr", {54'h0, men_last_addr}, {54'h0, 10'h004});
        chk("t2_mem_en_count", 64'(men_cnt - c0), 64'h1);

        // 3: store then load the same word; inputs changed mid-access are ignored
        tick();
        c0 = mwe_cnt;
        dm_addr = 10'h010; dm_wdata = 32'hDEAD_BEEF; dm_we = 1'b1; dm_req = 1'b1;
        dm_q.push_back('{data: 32'h1000_0030, ack_cyc: -1});
        tick();
        dm_addr = 10'h3FF; dm_wdata = 32'h0BAD_0BAD;
        serve(20);
        chk("t3_store_we_count", 64'(mwe_cnt - c0), 64'h1);
        tick();
        dm_addr = 10'h010; dm_we = 1'b0; dm_wdata = 32'h0; dm_req = 1'b1;
        dm_q.push_back('{data: 32'hDEAD_BEEF, ack_cyc: -1});
        serve(20);
        chk("t3_load_no_we", 64'(mwe_cnt - c0), 64'h1);

        // 4: both held continuously -> DM,DM,DM,IF,DM,DM,DM,IF
        tick();
        if_addr = 10'h004; dm_addr = 10'h040; dm_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) begin
                order_q.push_back(1'b0);
                if_q.push_back('{data: 32'h2001_0005, ack_cyc: -1});
            end else begin
                order_q.push_back(1'b1);
                dm_q.push_back('{data: 32'h1000_0040, ack_cyc: -1});
            end
        end
        order_chk = 1'b1;
        if_req = 1'b1; dm_req = 1'b1;
        continuous(8, 60);
        order_chk = 1'b0;
        chk("t4_order_drained", 64'(order_q.size()), 64'h0);

        // 5: reset during WAIT of a fetch; that fetch never acks
        tick();
        if_addr = 10'h020; if_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_if_ack", {63'h0, if_ack}, 64'h0);
        chk("t5_rst_stall", {63'h0, pipe_stall}, 64'h0);
        chk("t5_rst_mem_en", {63'h0, mem_en}, 64'h0);
        chk("t5_rst_if_rdata", {32'h0, if_rdata}, 64'h0);
        tick();
        if_req = 1'b0;
        tick();
        reset = 1'b1;
        c0 = men_cnt;
        repeat (6) tick();
        chk("t5_no_access_after_rst", 64'(men_cnt - c0), 64'h0);
        t = cyc;
        if_addr = 10'h004; if_req = 1'b1;
        if_q.push_back('{data: 32'h2001_0005, ack_cyc: t + 4});
        serve(20);

        // 6: pipe_stall across a lone data load
        tick();
        t = cyc;
        dm_addr = 10'h030; dm_we = 1'b0; dm_req = 1'b1;
        dm_q.push_back('{data: 32'h1000_0030, ack_cyc: t + 4});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6_stall", {63'h0, pipe_stall}, {63'h0, (c < 4)});
            tick();
        end
        dm_req = 1'b0;
        @(negedge clk);
        chk("t6_stall_after", {63'h0, pipe_stall}, 64'h0);

        repeat (3) tick();
        chk("if_q_empty", 64'(if_q.size()), 64'h0);
        chk("dm_q_empty", 64'(dm_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
